// File: rtl/adder_arbiter_pkg.sv
// Shared types and helpers for the adder arbiter.
// Latency: none (types and elaboration-time functions only).
// Backpressure: not applicable.
package adder_arbiter_pkg;

    // Storage limits for the result entry; DATA_WIDTH up to 32, NUM_REQ up to 16.
    localparam int MAX_DATA_WIDTH = 32;
    localparam int MAX_ID_W       = 4;

    // Requester index width; a single requester line still needs one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // One buffered result: carry-extended sum plus originating requester.
    typedef struct packed {
        logic [MAX_DATA_WIDTH:0] x;
        logic [MAX_ID_W-1:0]     id;
    } result_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or after ptr wins.
// Latency: purely combinational.
// Backpressure: enable low forces an all-zero grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    logic            found;
    logic [ID_W-1:0] cand;

    // Scan requesters in rotated order starting at ptr; first valid one wins.
    always_comb begin
        int pos;
        pos   = 0;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cand = ID_W'(pos);
            if (!found && req[cand]) begin
                found       = 1'b1;
                idx         = cand;
                grant[cand] = enable;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Arbitrates NUM_REQ operand sources round-robin, adds A+B, queues {sum, id}.
// Latency: 1 cycle from acceptance to rsp_valid when the 2-entry queue is empty.
// Backpressure: req_ready only when the queue has room or pops this cycle.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_REQ    = 4,
    localparam int ID_W      = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH:0]           rsp_x,
    output logic [ID_W-1:0]               rsp_id
);

    logic [ID_W-1:0]       ptr;
    logic [1:0]            count;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  active;
    result_t               mem [2];
    result_t               head;
    result_t               new_entry;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  space;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] a_sel;
    logic [DATA_WIDTH-1:0] b_sel;
    logic [DATA_WIDTH:0]   sum;
    logic                  unused_head;

    // A slot frees up this cycle if the head is being consumed.
    assign rsp_valid = (count != 2'd0);
    assign pop       = rsp_valid && rsp_ready;
    assign space     = (count < 2'd2) || pop;

    // active keeps req_ready low during reset and on the first edge after release.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .enable (active && space),
        .grant  (grant),
        .idx    (grant_idx)
    );

    assign req_ready = grant;
    assign push      = |grant;

    // Only the granted requester's operands reach the adder.
    assign a_sel = req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign b_sel = req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sum   = {1'b0, a_sel} + {1'b0, b_sel};

    // Build the queue entry, zero-filling unused storage bits.
    always_comb begin
        new_entry    = '0;
        new_entry.x  = (MAX_DATA_WIDTH + 1)'(sum);
        new_entry.id = MAX_ID_W'(grant_idx);
    end

    // Head of queue drives the response; entries are cleared on reset so outputs read zero.
    assign head        = mem[rd_ptr];
    assign rsp_x       = head.x[DATA_WIDTH:0];
    assign rsp_id      = head.id[ID_W-1:0];
    assign unused_head = ^head;

    // Queue pointers, occupancy, storage and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            ptr    <= '0;
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            active <= 1'b1;
            // When full, push and pop hit the same slot: the old head leaves as the new entry lands.
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= ~wr_ptr;
                if (grant_idx == ID_W'(NUM_REQ - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= grant_idx + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, operand width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters, legal range 2..16.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester operand-valid.
REQ-006 SHALL have port req_ready  output  NUM_REQ  per-requester accept strobe.
REQ-007 SHALL have port req_a  input  NUM_REQ x DATA_WIDTH  per-requester operand A, unsigned.
REQ-008 SHALL have port req_b  input  NUM_REQ x DATA_WIDTH  per-requester operand B, unsigned.
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port rsp_x  output  DATA_WIDTH+1  sum, unsigned, carry in MSB.
REQ-012 SHALL have port rsp_id  output  ID_W = max(1, clog2(NUM_REQ))  index of originating requester.

Function
REQ-013 SHALL grant at most one requester per cycle, round-robin, starting search at priority pointer ptr.
REQ-014 SHALL assert req_ready[i] only for the granted requester i, and only when space = (count < 2) or (rsp_valid and rsp_ready).
REQ-015 SHALL count a request accepted when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-016 SHALL on acceptance push {req_a[i] + req_b[i] zero-extended to DATA_WIDTH+1, i} into a 2-entry result FIFO.
REQ-017 SHALL on acceptance set ptr to (i+1) mod NUM_REQ; ptr SHALL hold when nothing is accepted.
REQ-018 SHALL drive rsp_valid = (count != 0); rsp_x/rsp_id SHALL show the FIFO head.
REQ-019 SHALL pop the head when rsp_valid and rsp_ready are both high at a rising edge.
REQ-020 SHALL give latency of exactly 1 cycle: accepted at edge N into empty FIFO -> rsp_valid high after edge N.
REQ-021 SHALL on simultaneous push and pop keep count unchanged, including when count = 2 (full).
REQ-022 SHALL never overflow (no push when full without pop) nor underflow (no pop when empty); count in {0,1,2}.
REQ-023 SHALL deliver results in acceptance order.
REQ-024 SHALL keep rsp_x/rsp_id stable while rsp_valid high and rsp_ready low.
REQ-025 SHALL not depend on req_a/req_b of non-granted requesters; req_ready SHALL not depend combinationally on rsp_x.
REQ-026 SHALL keep grant logic combinational from req_valid, ptr, count, rsp_valid, rsp_ready; all outputs except req_ready registered.

Reset
REQ-027 SHALL on rst_n low immediately (asynchronously) clear count to 0, ptr to 0, FIFO read/write pointers to 0.
REQ-028 SHALL during reset drive rsp_valid = 0, rsp_x = 0, rsp_id = 0, req_ready = all 0.
REQ-029 SHALL discard any buffered results on reset mid-operation; first post-reset grant search starts at requester 0.
REQ-030 SHALL have no accepted transaction on the first rising edge while rst_n is low.

Structure
REQ-031 SHALL place ID_W computation function and result-entry struct {x, id} in package adder_arbiter_pkg.
REQ-032 SHALL implement round-robin grant as sub-module rr_arbiter (inputs: request vector, ptr, enable; output: one-hot grant, index).
REQ-033 SHALL implement FIFO storage inline in adder_arbiter.

Verification (DATA_WIDTH=4, NUM_REQ=4)
REQ-034 SHALL test: requester 2 only, A=15, B=15, rsp_ready=1 -> next cycle rsp_valid=1, rsp_x=30, rsp_id=2.
REQ-035 SHALL test: all four valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0, one result per cycle.
REQ-036 SHALL test: rsp_ready=0, all valid -> exactly two accepts (ids 0,1), then req_ready=0 until rsp_ready rises.
REQ-037 SHALL test: FIFO full, rsp_ready=1, requester 3 valid A=7 B=9 -> push and pop same edge, count stays 2, later rsp_x=16 id=3.
REQ-038 SHALL test: rst_n low mid-stream with count=2 -> rsp_valid=0 immediately; after release, requesters 1 and 3 valid -> grant 1 first.
REQ-039 SHALL test: random valid/ready traffic 10000 cycles -> every result matches A+B of its requester, in order, none lost or duplicated.
